// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter, the per-core control units and the memory block.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam int DEF_NCORES  = 4;
    localparam int DEF_AW      = 16;
    localparam int DEF_DW      = 8;
    localparam int DEF_MEM_LAT = 2;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-request and memory-port bundle of the data-memory arbiter.
// Handshake: a core holds REQRD/REQWR (with ADDR/WDATA stable) until it sees its one-cycle ACK, then drops them.
interface mem_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW     = 16,
    parameter int DW     = 8
);
    logic [NCORES-1:0]    REQRD;
    logic [NCORES-1:0]    REQWR;
    logic [NCORES*AW-1:0] ADDR;
    logic [NCORES*DW-1:0] WDATA;
    logic [NCORES-1:0]    ACK;
    logic [NCORES-1:0]    GNT;
    logic [DW-1:0]        RDATA;
    logic                 BUSY;
    logic [AW-1:0]        MEMADDR;
    logic [DW-1:0]        MEMWDATA;
    logic                 MEMREAD;
    logic                 MEMWR;
    logic [DW-1:0]        MEMRDATA;

    // Cores and memory together form the master side; the arbiter is the slave.
    modport master (
        output REQRD, REQWR, ADDR, WDATA, MEMRDATA,
        input  ACK, GNT, RDATA, BUSY, MEMADDR, MEMWDATA, MEMREAD, MEMWR
    );

    modport slave (
        input  REQRD, REQWR, ADDR, WDATA, MEMRDATA,
        output ACK, GNT, RDATA, BUSY, MEMADDR, MEMWDATA, MEMREAD, MEMWR
    );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_i (wrapping) wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    int cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last_i) + k;
            if (cand >= N) cand = cand - N;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the per-core control units.
// IDLE arbitrates, ACCESS holds the strobe for MEM_LAT cycles, DONE pulses the winner's ACK.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NCORES  = DEF_NCORES,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic         clk,
    input  logic         rstn,
    mem_arbiter_if.slave bus,
    output arb_state_e   dbg_state_o
);
    localparam int IW = idx_width(NCORES);
    localparam int CW = idx_width(MEM_LAT);

    arb_state_e        state_q;
    logic [IW-1:0]     last_q;
    logic [CW-1:0]     cnt_q;
    logic [NCORES-1:0] gnt_q;
    logic [NCORES-1:0] ack_q;
    logic [DW-1:0]     rdata_q;
    logic [AW-1:0]     memaddr_q;
    logic [DW-1:0]     memwdata_q;
    logic              memread_q;
    logic              memwr_q;

    logic [NCORES-1:0] pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic [AW-1:0]     addr_d;
    logic [DW-1:0]     wdata_d;
    logic              wr_d;

    rr_pick #(.N(NCORES), .IW(IW)) u_pick (
        .req_i  (bus.REQRD | bus.REQWR),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .valid_o(pick_valid)
    );

    // Write wins when a core raises both request lines.
    always_comb begin
        addr_d  = bus.ADDR[int'(pick_idx)*AW +: AW];
        wdata_d = bus.WDATA[int'(pick_idx)*DW +: DW];
        wr_d    = bus.REQWR[pick_idx];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            last_q     <= IW'(NCORES - 1);
            cnt_q      <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            memaddr_q  <= '0;
            memwdata_q <= '0;
            memread_q  <= 1'b0;
            memwr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= '0;
                    if (pick_valid) begin
                        gnt_q      <= pick_gnt;
                        last_q     <= pick_idx;
                        memaddr_q  <= addr_d;
                        memwdata_q <= wdata_d;
                        memwr_q    <= wr_d;
                        memread_q  <= !wr_d;
                        cnt_q      <= CW'(MEM_LAT - 1);
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (memread_q) rdata_q <= bus.MEMRDATA;
                        memread_q <= 1'b0;
                        memwr_q   <= 1'b0;
                        gnt_q     <= '0;
                        ack_q     <= gnt_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.GNT      = gnt_q;
    assign bus.ACK      = ack_q;
    assign bus.RDATA    = rdata_q;
    assign bus.BUSY     = (state_q != IDLE);
    assign bus.MEMADDR  = memaddr_q;
    assign bus.MEMWDATA = memwdata_q;
    assign bus.MEMREAD  = memread_q;
    assign bus.MEMWR    = memwr_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random multi-core traffic, all checked against
// a cycle-timeline model of the round-robin rules through an expected-access queue.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NC  = 4;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 2;

    typedef struct packed {
        logic [2:0]    core;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [31:0]   gcyc;
    } exp_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    arb_state_e dbg_state;

    mem_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / memory ----------------
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hE5;
    endfunction

    assign bus.MEMRDATA = rom(bus.MEMADDR);

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [NC-1:0] onehot(input int i);
        logic [NC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    exp_t          exp_q[$];
    int            gnt_log[$];
    int            cyc        = 0;
    int            last_m     = NC - 1;
    int            next_arb   = 1;
    int            strobe_len = 0;
    logic [DW-1:0] exp_rdata  = '0;
    logic [NC-1:0] prev_gnt   = '0;
    logic [NC-1:0] m_pend;
    exp_t          m_e;
    int            m_c;
    bit            m_found;

    // Monitor + reference model: arbitration happens every cycle the arbiter is free; a win
    // occupies grant cycles g..g+LAT-1, ACK at g+LAT, and the next free cycle is g+LAT+1.
    always @(negedge clk) begin
        cyc++;
        if (bus.MEMREAD || bus.MEMWR) strobe_len++;

        if (exp_q.size() > 0 && cyc == int'(exp_q[0].gcyc)) begin
            m_e = exp_q[0];
            chk("gnt", bus.GNT, onehot(int'(m_e.core)));
            chk("strobe_wr_rd", {bus.MEMWR, bus.MEMREAD}, m_e.wr ? 2'b10 : 2'b01);
            chk("memaddr", bus.MEMADDR, m_e.addr);
            if (m_e.wr) chk("memwdata", bus.MEMWDATA, m_e.wdata);
            chk("busy_access", bus.BUSY, 1);
            gnt_log.push_back(int'(m_e.core));
        end else if (bus.GNT != '0 && prev_gnt == '0) begin
            chk("unexpected_gnt", bus.GNT, 0);
        end

        if (exp_q.size() > 0 && cyc == int'(exp_q[0].gcyc) + LAT) begin
            m_e = exp_q.pop_front();
            if (!m_e.wr) exp_rdata = rom(m_e.addr);
            chk("ack", bus.ACK, onehot(int'(m_e.core)));
            chk("rdata", bus.RDATA, exp_rdata);
            chk("strobe_len", strobe_len, LAT);
            strobe_len = 0;
        end else if (bus.ACK != '0) begin
            chk("unexpected_ack", bus.ACK, 0);
        end
        prev_gnt = bus.GNT;

        if (!rstn) begin
            exp_q.delete();
            last_m     = NC - 1;
            next_arb   = cyc + 1;
            exp_rdata  = '0;
            strobe_len = 0;
        end else if (cyc == next_arb) begin
            chk("busy_idle", bus.BUSY, 0);
            m_pend   = bus.REQRD | bus.REQWR;
            next_arb = cyc + 1;
            m_found  = 1'b0;
            for (int k = 1; k <= NC; k++) begin
                m_c = (last_m + k) % NC;
                if (!m_found && m_pend[m_c]) begin
                    m_found   = 1'b1;
                    m_e.core  = 3'(m_c);
                    m_e.wr    = bus.REQWR[m_c];
                    m_e.addr  = bus.ADDR[m_c*AW +: AW];
                    m_e.wdata = bus.WDATA[m_c*DW +: DW];
                    m_e.gcyc  = 32'(cyc + 1);
                    exp_q.push_back(m_e);
                    last_m   = m_c;
                    next_arb = cyc + LAT + 2;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.REQRD[i]          = rd;
        bus.REQWR[i]          = wr;
        bus.ADDR[i*AW +: AW]  = a;
        bus.WDATA[i*DW +: DW] = d;
    endtask

    task automatic drop_req(input int i);
        bus.REQRD[i] = 1'b0;
        bus.REQWR[i] = 1'b0;
    endtask

    task automatic wait_ack(input int i);
        bit seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = bus.ACK[i];
        end
        chk($sformatf("ack_seen_core%0d", i), seen, 1);
        @(posedge clk);
        #1;
        drop_req(i);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = (bus.BUSY == 1'b0) && (exp_q.size() == 0);
        end
        chk("drain_idle", done, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int  gap[NC];
    bit  busy_c[NC];
    int  op;
    int  left;
    bit  seen_g;

    initial begin
        bus.REQRD = '0;
        bus.REQWR = '0;
        bus.ADDR  = '0;
        bus.WDATA = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {bus.GNT, bus.ACK, bus.RDATA, bus.BUSY, bus.MEMADDR,
                              bus.MEMWDATA, bus.MEMREAD, bus.MEMWR}, 0);
        chk("reset_state", dbg_state, IDLE);

        // Fairness: all cores request continuously from reset
        gnt_log.delete();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < NC; i++) set_req(i, 1'b1, 1'b0, AW'(16'h0100 * i + i), '0);
        repeat (21) @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) drop_req(i);
        wait_idle();
        for (int k = 0; k < 5; k++)
            chk($sformatf("fair_order_%0d", k), (gnt_log.size() > k) ? gnt_log[k] : -1, k % NC);

        // Single read, single write, read+write on the same core
        tick();
        set_req(2, 1'b1, 1'b0, 16'h0040, 8'h00);
        wait_ack(2);
        @(negedge clk);
        chk("single_read_rdata", bus.RDATA, 8'hA5);
        tick();
        set_req(0, 1'b0, 1'b1, 16'h0010, 8'h3C);
        wait_ack(0);
        @(negedge clk);
        chk("write_keeps_rdata", bus.RDATA, 8'hA5);
        tick();
        set_req(1, 1'b1, 1'b1, 16'h0123, 8'h77);
        wait_ack(1);
        wait_idle();

        // Core 3 withdraws during its access; core 1 must be served next
        tick();
        set_req(3, 1'b1, 1'b0, 16'h0300, 8'h00);
        set_req(1, 1'b1, 1'b0, 16'h0111, 8'h00);
        seen_g = 1'b0;
        for (int t = 0; t < 50 && !seen_g; t++) begin
            @(negedge clk);
            seen_g = bus.GNT[3];
        end
        chk("withdraw_gnt_core3", seen_g, 1);
        tick();
        drop_req(3);
        wait_ack(1);
        wait_idle();

        // Reset in the middle of an access
        tick();
        for (int i = 0; i < NC; i++) set_req(i, 1'b1, 1'b0, AW'(16'h0A00 + i), '0);
        seen_g = 1'b0;
        for (int t = 0; t < 50 && !seen_g; t++) begin
            @(negedge clk);
            seen_g = (bus.GNT != '0);
        end
        chk("pre_reset_gnt", seen_g, 1);
        tick();
        rstn = 1'b0;
        gnt_log.delete();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_abort", {bus.MEMREAD, bus.MEMWR, bus.GNT, bus.ACK, bus.BUSY, bus.RDATA}, 0);
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) drop_req(i);
        chk("post_reset_first_core", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
        wait_idle();

        // Random traffic with occasional mid-access withdrawal
        for (int i = 0; i < NC; i++) begin
            gap[i]    = 0;
            busy_c[i] = 1'b0;
        end
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int i = 0; i < NC; i++) begin
                if (busy_c[i]) begin
                    if (bus.ACK[i]) begin
                        drop_req(i);
                        busy_c[i] = 1'b0;
                        gap[i]    = int'($urandom_range(0, 6));
                    end else if (bus.GNT[i] && $urandom_range(0, 9) == 0) begin
                        drop_req(i);
                    end
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end else if (t < 2800 && $urandom_range(0, 3) == 0) begin
                    op = int'($urandom_range(0, 2));
                    set_req(i, op != 1, op != 0, AW'($urandom_range(0, 65535)),
                            DW'($urandom_range(0, 255)));
                    busy_c[i] = 1'b1;
                end
            end
        end
        left = 0;
        for (int i = 0; i < NC; i++) if (busy_c[i]) left++;
        chk("random_all_served", left, 0);
        wait_idle();
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single data-memory port between the per-core control units of the multicore processor. Each core's control unit raises a read or write request (driven from its MEMREAD/MEMWR microinstruction bits) and stalls its microsequencer until this block returns a one-cycle acknowledge. The arbiter serialises accesses, drives the memory strobes for a fixed latency, and returns read data to the granted core.

## Interface
- NCORES, 4, number of requesting cores (2..8)
- AW, 16, memory address width
- DW, 8, memory data width
- MEM_LAT, 2, cycles the memory strobe must be held per access (>=1)

- clk  in  1  system clock; all state changes on rising edge
- rstn  in  1  reset; one clock, synchronous, active-low
- REQRD  in  NCORES  per-core read request, level, held until ACK
- REQWR  in  NCORES  per-core write request, level, held until ACK
- ADDR  in  NCORES*AW  per-core address; core i at [i*AW +: AW]
- WDATA  in  NCORES*DW  per-core write data; core i at [i*DW +: DW]
- ACK  out  NCORES  one-hot, one-cycle completion pulse
- GNT  out  NCORES  one-hot grant, high for the whole access
- RDATA  out  DW  read data of the last completed read; held until the next read completes
- BUSY  out  1  high whenever state is not IDLE
- MEMADDR  out  AW  address to memory
- MEMWDATA  out  DW  write data to memory
- MEMREAD  out  1  memory read strobe
- MEMWR  out  1  memory write strobe
- MEMRDATA  in  DW  memory read data, valid in the last strobe cycle

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: active requests = REQRD | REQWR. If any are active, pick the winner round-robin starting at LAST+1 (mod NCORES). Register GNT, MEMADDR, MEMWDATA, the op and the winner into LAST, then go to ACCESS. If none are active, stay in IDLE.
- Op: if REQWR[i] is set, the access is a write, even when REQRD[i] is also set. Otherwise it is a read.
- ACCESS: MEMREAD or MEMWR is high. A down-counter loaded with MEM_LAT-1 decrements each cycle. At count 0:
  - on a read, capture MEMRDATA into RDATA;
  - go to DONE.
- DONE: strobes low, GNT low, ACK[LAST] high for one cycle. Always go to IDLE.
- Request inputs, ADDR and WDATA are sampled only in IDLE. Changes during ACCESS are ignored. If a request is withdrawn mid-access, the access still completes and ACK is still issued.
- Non-granted cores' requests remain pending. No request is lost or reordered within a core.
- Reset values: state IDLE, LAST = NCORES-1 (core 0 wins first), counter 0. All outputs are 0, including RDATA and MEMADDR.
- A reset mid-access aborts it immediately. No ACK is issued and the strobes drop at that edge.

## Timing
- Request high in IDLE at cycle 0 gives GNT and strobe at cycles 1..MEM_LAT and ACK at cycle MEM_LAT+1.
- Minimum spacing between grants is MEM_LAT+2 cycles. IDLE always costs one arbitration cycle.
- The core must drop its request at the edge ending its ACK cycle. Otherwise it is re-arbitrated as a new request.
- With all cores requesting continuously, each core is served once every NCORES*(MEM_LAT+2) cycles.
- Outputs are registered. The only combinational path is the round-robin pick into the IDLE-state registers.

## Structure
- Shared package/header: state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and default AW/DW/MEM_LAT constants shared with the control-unit and memory blocks.
- Sub-module rr_pick: combinational; inputs are the request vector and LAST; outputs are a one-hot winner and its index. Reused by future bus arbiters.

## Test plan
- Single read: core 2 REQRD, ADDR=0x0040, MEMRDATA=0xA5 (MEM_LAT=2) -> GNT=4'b0100 and MEMREAD in cycles 1-2, ACK=4'b0100 in cycle 3, RDATA=0xA5.
- Single write: core 0 REQWR, ADDR=0x0010, WDATA=0x3C -> MEMWR cycles 1-2 with MEMADDR=0x0010, MEMWDATA=0x3C, ACK[0] in cycle 3, RDATA unchanged.
- Fairness: all four cores request continuously from reset -> grant order 0,1,2,3,0. Each ACK is spaced 4 cycles apart; each core is served every 16 cycles.
- Simultaneous REQRD and REQWR on core 1 -> write performed (MEMWR high, MEMREAD low), single ACK[1].
- Request withdrawn mid-access: core 3 drops REQRD in cycle 2 -> access completes, ACK[3] in cycle 3. Next IDLE picks the next pending core.
- Reset mid-access: rstn low in cycle 2 -> next edge shows MEMREAD=0, GNT=0, no ACK, BUSY=0. First post-reset grant goes to core 0 when all cores request.
